// File: rtl/sr_ff_if.sv
// Bundle of the SR flip-flop's request inputs and state outputs.
// The stimulus side (master) drives s/r and watches the state.
// The flip-flop side (slave) receives s/r and drives the state.
interface sr_ff_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] conflict;

    modport master (
        output s,
        output r,
        input  q,
        input  qn,
        input  conflict
    );

    modport slave (
        input  s,
        input  r,
        output q,
        output qn,
        output conflict
    );
endinterface

// File: rtl/sr_ff.sv
// Bank of WIDTH independent clocked SR flip-flops.
// Each bit is updated on the rising clock edge from its own s/r pair.
// When s=r=1 the bit loads SET_DOMINANT[0], and its conflict flag is raised for one cycle.
// The reset is asynchronous and active-low. It forces q to RESET_VALUE and clears conflict.
// qn is a purely combinational inverse of q, so it follows reset without waiting for a clock.
module sr_ff #(
    parameter int               WIDTH        = 1,
    parameter int               SET_DOMINANT = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic   clk,
    input  logic   rst,
    sr_ff_if.slave bus
);
    // Value loaded when a bit samples s=r=1.
    localparam logic BOTH_VALUE = SET_DOMINANT[0];

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] conflict_reg;
    logic [WIDTH-1:0] conflict_next;

    // Per-bit next-state logic. Every bit uses only its own s/r pair and its own state.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign q_next[gi] = (bus.s[gi] &  bus.r[gi]) ? BOTH_VALUE :
                                (bus.s[gi] & ~bus.r[gi]) ? 1'b1       :
                                (~bus.s[gi] & bus.r[gi]) ? 1'b0       :
                                                           q_reg[gi];
            assign conflict_next[gi] = bus.s[gi] & bus.r[gi];
        end
    endgenerate

    // State register. Asserting reset overrides the clock immediately and aborts any pending update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg        <= RESET_VALUE;
            conflict_reg <= '0;
        end else begin
            q_reg        <= q_next;
            conflict_reg <= conflict_next;
        end
    end

    // Outputs come straight from the registers. There is no combinational path from s/r to q.
    assign bus.q        = q_reg;
    assign bus.qn       = ~q_reg;
    assign bus.conflict = conflict_reg;
endmodule

// File: tb/tb_sr_ff.sv
// Directed bench for sr_ff using three instances:
//   u0: WIDTH=1, reset-dominant
//   u1: WIDTH=1, set-dominant
//   u2: WIDTH=4, reset-dominant
// Expected post-edge results are queued when stimulus is applied.
// They are popped and checked 1ns after the next rising edge.
module tb_sr_ff;
    logic clk;
    logic rst;

    sr_ff_if #(.WIDTH(1)) bus0 ();
    sr_ff_if #(.WIDTH(1)) bus1 ();
    sr_ff_if #(.WIDTH(4)) bus2 ();

    sr_ff #(.WIDTH(1), .SET_DOMINANT(0), .RESET_VALUE(1'b0)) u0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );
    sr_ff #(.WIDTH(1), .SET_DOMINANT(1), .RESET_VALUE(1'b0)) u1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );
    sr_ff #(.WIDTH(4), .SET_DOMINANT(0), .RESET_VALUE(4'b0000)) u2 (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         unit;
        logic [3:0] q;
        logic [3:0] c;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [3:0] get_q(int unit);
        case (unit)
            0:       return {3'b000, bus0.q};
            1:       return {3'b000, bus1.q};
            default: return bus2.q;
        endcase
    endfunction

    function automatic logic [3:0] get_qn(int unit);
        case (unit)
            0:       return {3'b000, bus0.qn};
            1:       return {3'b000, bus1.qn};
            default: return bus2.qn;
        endcase
    endfunction

    function automatic logic [3:0] get_c(int unit);
        case (unit)
            0:       return {3'b000, bus0.conflict};
            1:       return {3'b000, bus1.conflict};
            default: return bus2.conflict;
        endcase
    endfunction

    function automatic logic [3:0] mask_of(int unit);
        return (unit == 2) ? 4'b1111 : 4'b0001;
    endfunction

    task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks q, qn and conflict of one unit against the given expectations.
    task automatic check_unit(string tag, int unit, logic [3:0] q_exp, logic [3:0] c_exp);
        check({tag, ".q"}, get_q(unit), q_exp);
        check({tag, ".qn"}, get_qn(unit), ~q_exp & mask_of(unit));
        check({tag, ".conflict"}, get_c(unit), c_exp);
        $display("t=%0t %s unit%0d q=%b qn=%b conflict=%b", $time, tag, unit,
                 get_q(unit), get_qn(unit), get_c(unit));
    endtask

    task automatic expect_after_edge(string tag, int unit, logic [3:0] q_exp, logic [3:0] c_exp);
        exp_t e;
        e.tag  = tag;
        e.unit = unit;
        e.q    = q_exp;
        e.c    = c_exp;
        sb.push_back(e);
    endtask

    // Advance one rising edge, then drain the scoreboard against the outputs.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_unit(e.tag, e.unit, e.q, e.c);
        end
    endtask

    task automatic idle_inputs();
        bus0.s = 1'b0;
        bus0.r = 1'b0;
        bus1.s = 1'b0;
        bus1.r = 1'b0;
        bus2.s = 4'b0000;
        bus2.r = 4'b0000;
    endtask

    // Watchdog: the sequence is a few dozen cycles, so this only fires on a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with s=1, r=0 applied. Outputs must show reset values throughout.
        rst    = 1'b0;
        bus0.s = 1'b1;
        bus0.r = 1'b0;
        bus1.s = 1'b1;
        bus1.r = 1'b0;
        bus2.s = 4'b1111;
        bus2.r = 4'b0000;
        #1;
        check_unit("reset_early", 0, 4'b0000, 4'b0000);
        expect_after_edge("reset_edge", 0, 4'b0000, 4'b0000);
        expect_after_edge("reset_edge_w4", 2, 4'b0000, 4'b0000);
        tick();
        #3;
        idle_inputs();
        rst = 1'b1;

        // Basic sequence on u0. Inputs change away from the edge.
        bus0.s = 1'b0; bus0.r = 1'b1;
        expect_after_edge("basic_r", 0, 4'b0000, 4'b0000);
        tick();
        bus0.s = 1'b1; bus0.r = 1'b1;
        expect_after_edge("basic_sr_conflict", 0, 4'b0000, 4'b0001);
        tick();
        bus0.s = 1'b0; bus0.r = 1'b1;
        expect_after_edge("basic_r_after_conflict", 0, 4'b0000, 4'b0000);
        tick();
        bus0.s = 1'b1; bus0.r = 1'b0;
        expect_after_edge("basic_s", 0, 4'b0001, 4'b0000);
        tick();
        bus0.s = 1'b0; bus0.r = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_after_edge($sformatf("basic_hold%0d", i), 0, 4'b0001, 4'b0000);
            tick();
        end

        // Set-dominant: from q=0, s=r=1 loads 1 and flags the conflict.
        check_unit("setdom_start", 1, 4'b0000, 4'b0000);
        bus1.s = 1'b1; bus1.r = 1'b1;
        expect_after_edge("setdom_sr", 1, 4'b0001, 4'b0001);
        tick();
        bus1.s = 1'b0; bus1.r = 1'b0;
        expect_after_edge("setdom_release", 1, 4'b0001, 4'b0000);
        tick();

        // Multi-bit independence.
        bus2.s = 4'b1010; bus2.r = 4'b0110;
        expect_after_edge("multibit", 2, 4'b1000, 4'b0010);
        tick();
        bus2.s = 4'b0000; bus2.r = 4'b0000;
        expect_after_edge("multibit_hold", 2, 4'b1000, 4'b0000);
        tick();

        // Put u1 into a conflict cycle so that reset must abort it.
        bus1.s = 1'b1; bus1.r = 1'b1;
        expect_after_edge("pre_async_conflict", 1, 4'b0001, 4'b0001);
        tick();

        // Async reset midway between edges. It takes effect before the next edge.
        #4;
        rst = 1'b0;
        #1;
        check_unit("async_u0", 0, 4'b0000, 4'b0000);
        check_unit("async_u1", 1, 4'b0000, 4'b0000);
        check_unit("async_u2", 2, 4'b0000, 4'b0000);

        // Held in reset across an edge with active requests.
        bus0.s = 1'b1; bus0.r = 1'b0;
        bus2.s = 4'b1111; bus2.r = 4'b0000;
        expect_after_edge("in_reset_u0", 0, 4'b0000, 4'b0000);
        expect_after_edge("in_reset_u1", 1, 4'b0000, 4'b0000);
        expect_after_edge("in_reset_u2", 2, 4'b0000, 4'b0000);
        tick();

        // Release mid-cycle. The first update comes from inputs sampled at the next edge.
        #3;
        rst = 1'b1;
        bus1.s = 1'b0; bus1.r = 1'b0;
        bus2.s = 4'b0101; bus2.r = 4'b1100;
        expect_after_edge("post_reset_u0", 0, 4'b0001, 4'b0000);
        expect_after_edge("post_reset_u2", 2, 4'b0001, 4'b0100);
        tick();

        // No-glitch: s/r toggle between edges but are 0/0 at every edge.
        for (int i = 0; i < 3; i++) begin
            bus0.s = 1'b0; bus0.r = 1'b1;
            bus2.s = 4'b0000; bus2.r = 4'b1111;
            #3;
            check_unit($sformatf("glitch_mid_a%0d", i), 0, 4'b0001, 4'b0000);
            bus0.s = 1'b1; bus0.r = 1'b1;
            bus2.s = 4'b1111; bus2.r = 4'b0000;
            #3;
            check_unit($sformatf("glitch_mid_b%0d", i), 2, 4'b0001, (i == 0) ? 4'b0100 : 4'b0000);
            idle_inputs();
            expect_after_edge($sformatf("glitch_edge_u0_%0d", i), 0, 4'b0001, 4'b0000);
            expect_after_edge($sformatf("glitch_edge_u2_%0d", i), 2, 4'b0001, 4'b0000);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sr_ff.md
SR_FF -- requirements
Module: sr_ff

Interface
REQ-001 Parameter WIDTH, default 1: number of independent SR flip-flop bits.
REQ-002 Parameter SET_DOMINANT, default 0: resolves S=R=1. 0 means reset wins (q<=0); 1 means set wins (q<=1).
REQ-003 Parameter RESET_VALUE, default 0 (WIDTH bits): q value loaded during reset.
REQ-004 Port clk, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port s, input, WIDTH bits: per-bit set request.
REQ-007 Port r, input, WIDTH bits: per-bit reset request.
REQ-008 Port q, output, WIDTH bits: registered flip-flop state.
REQ-009 Port qn, output, WIDTH bits: combinational bitwise inverse of q.
REQ-010 Port conflict, output, WIDTH bits: registered per-bit flag, 1 for the cycle after that bit sampled s=r=1.

Function
REQ-011 Each bit i SHALL update only on the rising edge of clk while rst=1.
REQ-012 s[i]=0, r[i]=0 SHALL hold q[i].
REQ-013 s[i]=0, r[i]=1 SHALL clear q[i] to 0 on the next rising edge.
REQ-014 s[i]=1, r[i]=0 SHALL set q[i] to 1 on the next rising edge.
REQ-015 s[i]=1, r[i]=1 SHALL load q[i]=SET_DOMINANT[0] and set conflict[i]=1 on the next rising edge.
REQ-016 conflict[i] SHALL be 0 after any edge where that bit did not sample s=r=1.
REQ-017 Latency SHALL be exactly one clock from input sampling to q and conflict update, with no combinational path from s or r to q.
REQ-018 qn SHALL equal ~q at all times, including during reset.
REQ-019 Bits SHALL be fully independent; no bit's inputs affect another bit.
REQ-020 Inputs SHALL be sampled using their value just before the rising edge; inputs that change coincident with the edge are the bench's responsibility to avoid.

Reset
REQ-021 rst=0 SHALL immediately, without waiting for clk, force q=RESET_VALUE, qn=~RESET_VALUE and conflict=0.
REQ-022 While rst=0, q and conflict SHALL hold their reset values regardless of clk, s and r.
REQ-023 On rst deassertion (0 to 1), the first state update SHALL occur at the next rising clk edge using s and r sampled at that edge.
REQ-024 Asserting rst mid-operation, including during a conflict cycle, SHALL abort any pending update and apply REQ-021.

Verification
REQ-025 Reset check: drive rst=0 for 1 clock with s=1, r=0 -> q=0, qn=1, conflict=0 throughout. Then rst=1.
REQ-026 Basic sequence (WIDTH=1, SET_DOMINANT=0), with inputs changed mid-cycle:
- s/r = 0/1 -> q=0
- s/r = 1/1 -> q=0, conflict=1
- s/r = 0/1 -> q=0, conflict=0
- s/r = 1/0 -> q=1
- s/r = 0/0 -> q stays 1 for 10 clocks
REQ-027 Set-dominant: with SET_DOMINANT=1 and q=0, apply s=1, r=1 -> q=1 and conflict=1 after one edge.
REQ-028 Async reset: with q=1, pull rst low midway between edges -> q=0 before the next clk edge.
REQ-029 Multi-bit (WIDTH=4): from q=4'b0000, apply s=4'b1010, r=4'b0110 -> q=4'b1000 and conflict=4'b0010.
REQ-030 Hold/no-glitch: toggle s and r between edges, returning them to 0/0 before each edge -> q never changes.
